// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM state codes and flag bit positions.
package alu_pkg;

  localparam int OP_W     = 6;
  localparam int NB_FLAGS = 4;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  // State encodings double as the debug LED codes.
  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'b001,
    ST_WAIT_B  = 3'b010,
    ST_WAIT_OP = 3'b011,
    ST_EXEC    = 3'b100,
    ST_SHOW    = 3'b111
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Board-side signals of the ALU sequencer: switches and buttons in, result LEDs out.
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int NB_DATA_BUS = 8,
  parameter int NB_DBG_LED  = 3
);
  logic [NB_DATA_BUS-1:0] i_switch;
  logic                   i_btn_enter;
  logic                   i_btn_back;
  logic [NB_DATA_BUS-1:0] o_led;
  logic [NB_FLAGS-1:0]    o_flags;
  logic                   o_valid;
  logic [NB_DBG_LED-1:0]  o_led_dbg;

  modport master (
    output i_switch, i_btn_enter, i_btn_back,
    input  o_led, o_flags, o_valid, o_led_dbg
  );

  modport slave (
    input  i_switch, i_btn_enter, i_btn_back,
    output o_led, o_flags, o_valid, o_led_dbg
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int NB_DATA_BUS = 8,
  parameter int NB_OPCODE   = 6
) (
  input  logic [NB_DATA_BUS-1:0] i_data_a,
  input  logic [NB_DATA_BUS-1:0] i_data_b,
  input  logic [NB_OPCODE-1:0]   i_opcode,
  output logic [NB_DATA_BUS-1:0] o_result
);
  logic [OP_W-1:0] op_ext;
  assign op_ext = OP_W'(i_opcode);

  always_comb begin
    o_result = '0;
    case (op_ext)
      OP_ADD:  o_result = i_data_a + i_data_b;
      OP_SUB:  o_result = i_data_a - i_data_b;
      OP_AND:  o_result = i_data_a & i_data_b;
      OP_OR:   o_result = i_data_a | i_data_b;
      OP_XOR:  o_result = i_data_a ^ i_data_b;
      OP_NOR:  o_result = ~(i_data_a | i_data_b);
      OP_SRA:  o_result = $unsigned($signed(i_data_a) >>> i_data_b);
      OP_SRL:  o_result = i_data_a >> i_data_b;
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/button_conditioner.sv
// Synchronises a raw button, debounces it and emits a 1-cycle pulse on each accepted press.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic i_clock,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses <= so all stages sample the pre-edge values together.
  always_ff @(posedge i_clock) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      pulse <= 1'b0;
      cnt   <= '0;
    end else begin
      meta  <= btn_raw;
      sync  <= meta;
      deb_d <= deb;
      pulse <= deb & ~deb_d;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_sequencer_top.sv
// Two-button operand/opcode sequencer around the combinational alu, with registered result and flags.
module alu_sequencer_top
  import alu_pkg::*;
#(
  parameter int NB_DATA_BUS     = 8,
  parameter int NB_OPCODE       = 6,
  parameter int NB_DBG_LED      = 3,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input logic            i_clock,
  input logic            reset,
  alu_sequencer_if.slave bus
);
  localparam int MSB = NB_DATA_BUS - 1;

  logic [NB_DATA_BUS-1:0] sw_meta, sw_sync;
  logic                   enter_pulse, back_pulse;
  state_t                 state_q, state_d;
  logic                   cap_a, cap_b, cap_op, load_res;
  logic [NB_DATA_BUS-1:0] a_q, b_q, led_q, alu_result, res;
  logic [NB_OPCODE-1:0]   op_q;
  logic [NB_FLAGS-1:0]    flags_q, flags_d;
  logic [NB_DBG_LED-1:0]  dbg_q;
  logic [NB_DATA_BUS:0]   sum;
  logic [OP_W-1:0]        op_ext;
  logic                   op_valid;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .i_clock(i_clock), .reset(reset), .btn_raw(bus.i_btn_enter), .pulse(enter_pulse)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .i_clock(i_clock), .reset(reset), .btn_raw(bus.i_btn_back), .pulse(back_pulse)
  );

  alu #(.NB_DATA_BUS(NB_DATA_BUS), .NB_OPCODE(NB_OPCODE)) u_alu (
    .i_data_a(a_q), .i_data_b(b_q), .i_opcode(op_q), .o_result(alu_result)
  );

  // NOTE: all always_comb outputs get a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    cap_op   = 1'b0;
    load_res = 1'b0;
    case (state_q)
      ST_WAIT_A:  if (enter_pulse) begin cap_a = 1'b1; state_d = ST_WAIT_B; end
      ST_WAIT_B:  if (enter_pulse) begin cap_b = 1'b1; state_d = ST_WAIT_OP; end
                  else if (back_pulse) state_d = ST_WAIT_A;
      ST_WAIT_OP: if (enter_pulse) begin cap_op = 1'b1; state_d = ST_EXEC; end
                  else if (back_pulse) state_d = ST_WAIT_B;
      ST_EXEC:    begin load_res = 1'b1; state_d = ST_SHOW; end
      ST_SHOW:    if (enter_pulse) state_d = ST_WAIT_A;
                  else if (back_pulse) state_d = ST_WAIT_OP;
      default:    state_d = ST_WAIT_A;
    endcase
  end

  // Flags are derived from the held operands so EXEC only has to register them.
  always_comb begin
    op_ext   = OP_W'(op_q);
    op_valid = is_valid_op(op_ext);
    sum      = {1'b0, a_q} + {1'b0, b_q};
    res      = op_valid ? alu_result : '0;
    flags_d  = '0;
    flags_d[FLAG_ZERO] = (res == '0);
    flags_d[FLAG_ERR]  = ~op_valid;
    if (op_ext == OP_ADD) begin
      flags_d[FLAG_CARRY] = sum[NB_DATA_BUS];
      flags_d[FLAG_OVF]   = (a_q[MSB] == b_q[MSB]) && (res[MSB] != a_q[MSB]);
    end else if (op_ext == OP_SUB) begin
      flags_d[FLAG_CARRY] = (a_q < b_q);
      flags_d[FLAG_OVF]   = (a_q[MSB] != b_q[MSB]) && (res[MSB] != a_q[MSB]);
    end
  end

  always_ff @(posedge i_clock) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      state_q <= ST_WAIT_A;
      dbg_q   <= NB_DBG_LED'(ST_WAIT_A);
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      led_q   <= '0;
      flags_q <= '0;
    end else begin
      sw_meta <= bus.i_switch;
      sw_sync <= sw_meta;
      state_q <= state_d;
      dbg_q   <= NB_DBG_LED'(state_d);
      if (cap_a)  a_q  <= sw_sync;
      if (cap_b)  b_q  <= sw_sync;
      if (cap_op) op_q <= sw_sync[NB_OPCODE-1:0];
      if (load_res) begin
        led_q   <= res;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.o_led     = led_q;
  assign bus.o_flags   = flags_q;
  assign bus.o_valid   = (state_q == ST_SHOW);
  assign bus.o_led_dbg = dbg_q;
endmodule
